// File: rtl/noc_net_iface.sv
// Network interface between a local client and a mesh router port.
// TX: client queue, credit-based flow control toward the router. RX: FWFT queue with credit return.
module noc_net_iface #(
  parameter int XCOORD    = 0,
  parameter int YCOORD    = 0,
  parameter int CREDITS   = 4,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [3:0]  tx_dest_x_i,
  input  logic [3:0]  tx_dest_y_i,
  input  logic [7:0]  tx_payload_i,
  output logic [15:0] rtr_data_o,
  output logic        rtr_enable_o,
  input  logic        rtr_credit_i,
  input  logic [15:0] rtr_data_i,
  input  logic        rtr_enable_i,
  output logic        rtr_credit_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [15:0] rx_data_o,
  output logic [1:0]  err_o,
  output logic [15:0] tx_count_o,
  output logic [15:0] rx_count_o
);

  localparam int TAW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int RAW = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
  localparam int CW  = $clog2(CREDITS + 1);

  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]  CRED_ONE = CW'(1);
  localparam logic [TAW:0]   TXQ_FULL = (TAW + 1)'(TXQ_DEPTH);
  localparam logic [TAW:0]   TXC_ONE  = (TAW + 1)'(1);
  localparam logic [TAW-1:0] TXP_ONE  = TAW'(1);
  localparam logic [RAW:0]   RXQ_FULL = (RAW + 1)'(RXQ_DEPTH);
  localparam logic [RAW:0]   RXC_ONE  = (RAW + 1)'(1);
  localparam logic [RAW-1:0] RXP_ONE  = RAW'(1);

  // Elaboration-time guards on the parameter ranges the pointer arithmetic relies on.
  if (TXQ_DEPTH < 2 || (TXQ_DEPTH & (TXQ_DEPTH - 1)) != 0) begin : g_bad_txq
    $error("TXQ_DEPTH must be a power of two and at least 2");
  end
  if (RXQ_DEPTH < 2 || (RXQ_DEPTH & (RXQ_DEPTH - 1)) != 0) begin : g_bad_rxq
    $error("RXQ_DEPTH must be a power of two and at least 2");
  end
  if (CREDITS < 1) begin : g_bad_cred
    $error("CREDITS must be at least 1");
  end
  if (XCOORD < 0 || XCOORD > 15 || YCOORD < 0 || YCOORD > 15) begin : g_bad_coord
    $error("XCOORD and YCOORD must fit in 4 bits");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_CRED = 2'd2
  } tx_state_t;

  tx_state_t      state_r;
  logic [15:0]    txq_mem_r [TXQ_DEPTH];
  logic [TAW-1:0] txq_wr_ptr_r;
  logic [TAW-1:0] txq_rd_ptr_r;
  logic [TAW:0]   txq_cnt_r;
  logic [TAW:0]   txq_cnt_next_s;
  logic           txq_full_s;
  logic           tx_push_s;
  logic           tx_pop_s;
  logic [CW-1:0]  credit_cnt_r;
  logic [CW-1:0]  credit_next_s;
  logic           cred_ovf_s;

  logic [15:0]    rxq_mem_r [RXQ_DEPTH];
  logic [RAW-1:0] rxq_wr_ptr_r;
  logic [RAW-1:0] rxq_rd_ptr_r;
  logic [RAW:0]   rxq_cnt_r;
  logic           rxq_full_s;
  logic           rxq_empty_s;
  logic           rx_push_s;
  logic           rx_pop_s;
  logic           rx_drop_s;

  assign txq_full_s = (txq_cnt_r == TXQ_FULL);
  assign tx_ready_o = !txq_full_s;
  assign tx_push_s  = tx_valid_i && !txq_full_s;
  // SEND is only entered with a non-empty queue and a credit in hand, so it is the send strobe.
  assign tx_pop_s   = (state_r == SEND);

  always_comb begin
    txq_cnt_next_s = txq_cnt_r;
    if (tx_push_s && !tx_pop_s) begin
      txq_cnt_next_s = txq_cnt_r + TXC_ONE;
    end else if (!tx_push_s && tx_pop_s) begin
      txq_cnt_next_s = txq_cnt_r - TXC_ONE;
    end else begin
      txq_cnt_next_s = txq_cnt_r;
    end
  end

  always_comb begin
    credit_next_s = credit_cnt_r;
    cred_ovf_s    = 1'b0;
    if (rtr_credit_i && !tx_pop_s) begin
      if (credit_cnt_r == CRED_MAX) begin
        cred_ovf_s = 1'b1;
      end else begin
        credit_next_s = credit_cnt_r + CRED_ONE;
      end
    end else if (!rtr_credit_i && tx_pop_s) begin
      credit_next_s = credit_cnt_r - CRED_ONE;
    end else begin
      credit_next_s = credit_cnt_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txq_wr_ptr_r <= '0;
      txq_rd_ptr_r <= '0;
      txq_cnt_r    <= '0;
      for (int i = 0; i < TXQ_DEPTH; i++) begin
        txq_mem_r[i] <= 16'h0000;
      end
    end else begin
      if (tx_push_s) begin
        txq_mem_r[txq_wr_ptr_r] <= {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
        txq_wr_ptr_r            <= txq_wr_ptr_r + TXP_ONE;
      end
      if (tx_pop_s) begin
        txq_rd_ptr_r <= txq_rd_ptr_r + TXP_ONE;
      end
      txq_cnt_r <= txq_cnt_next_s;
    end
  end

  // Next state uses post-update occupancy and credits so back-to-back sends need no idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      credit_cnt_r <= CRED_MAX;
      rtr_data_o   <= 16'h0000;
      rtr_enable_o <= 1'b0;
      tx_count_o   <= 16'h0000;
    end else begin
      rtr_enable_o <= 1'b0;
      case (state_r)
        SEND: begin
          rtr_data_o   <= txq_mem_r[txq_rd_ptr_r];
          rtr_enable_o <= 1'b1;
          tx_count_o   <= tx_count_o + 16'd1;
        end
        IDLE, WAIT_CRED: begin
          rtr_enable_o <= 1'b0;
        end
        default: begin
          rtr_enable_o <= 1'b0;
        end
      endcase
      credit_cnt_r <= credit_next_s;
      if (txq_cnt_next_s == '0) begin
        state_r <= IDLE;
      end else if (credit_next_s == '0) begin
        state_r <= WAIT_CRED;
      end else begin
        state_r <= SEND;
      end
    end
  end

  assign rxq_empty_s = (rxq_cnt_r == '0);
  assign rxq_full_s  = (rxq_cnt_r == RXQ_FULL);
  assign rx_pop_s    = !rxq_empty_s && rx_ready_i;
  // A pop in the same cycle frees the slot, so a full queue still takes the incoming flit.
  assign rx_push_s   = rtr_enable_i && (!rxq_full_s || rx_pop_s);
  assign rx_drop_s   = rtr_enable_i && rxq_full_s && !rx_pop_s;
  assign rx_valid_o  = !rxq_empty_s;
  assign rx_data_o   = rxq_mem_r[rxq_rd_ptr_r];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxq_wr_ptr_r <= '0;
      rxq_rd_ptr_r <= '0;
      rxq_cnt_r    <= '0;
      rx_count_o   <= 16'h0000;
      rtr_credit_o <= 1'b0;
      for (int i = 0; i < RXQ_DEPTH; i++) begin
        rxq_mem_r[i] <= 16'h0000;
      end
    end else begin
      rtr_credit_o <= rx_pop_s;
      if (rx_push_s) begin
        rxq_mem_r[rxq_wr_ptr_r] <= rtr_data_i;
        rxq_wr_ptr_r            <= rxq_wr_ptr_r + RXP_ONE;
        rx_count_o              <= rx_count_o + 16'd1;
      end
      if (rx_pop_s) begin
        rxq_rd_ptr_r <= rxq_rd_ptr_r + RXP_ONE;
      end
      if (rx_push_s && !rx_pop_s) begin
        rxq_cnt_r <= rxq_cnt_r + RXC_ONE;
      end else if (!rx_push_s && rx_pop_s) begin
        rxq_cnt_r <= rxq_cnt_r - RXC_ONE;
      end else begin
        rxq_cnt_r <= rxq_cnt_r;
      end
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 2'b00;
    end else begin
      err_o <= err_o | {rx_drop_s, cred_ovf_s};
    end
  end

endmodule

// File: tb/tb_noc_net_iface.sv
// Scoreboard bench for noc_net_iface: stimulus pushes expected flits, a negedge monitor checks them.
module tb_noc_net_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [3:0]  tx_dest_x_i;
  logic [3:0]  tx_dest_y_i;
  logic [7:0]  tx_payload_i;
  logic [15:0] rtr_data_o;
  logic        rtr_enable_o;
  logic        rtr_credit_i;
  logic [15:0] rtr_data_i;
  logic        rtr_enable_i;
  logic        rtr_credit_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [15:0] rx_data_o;
  logic [1:0]  err_o;
  logic [15:0] tx_count_o;
  logic [15:0] rx_count_o;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] tx_exp[$];
  logic [15:0] rx_exp[$];

  noc_net_iface #(.XCOORD(0), .YCOORD(0), .CREDITS(4), .TXQ_DEPTH(4), .RXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_dest_x_i(tx_dest_x_i), .tx_dest_y_i(tx_dest_y_i), .tx_payload_i(tx_payload_i),
    .rtr_data_o(rtr_data_o), .rtr_enable_o(rtr_enable_o), .rtr_credit_i(rtr_credit_i),
    .rtr_data_i(rtr_data_i), .rtr_enable_i(rtr_enable_i), .rtr_credit_o(rtr_credit_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .err_o(err_o), .tx_count_o(tx_count_o), .rx_count_o(rx_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] x, input logic [3:0] y, input logic [7:0] p,
                          input logic [15:0] exp);
    bit done = 1'b0;
    tx_valid_i   = 1'b1;
    tx_dest_x_i  = x;
    tx_dest_y_i  = y;
    tx_payload_i = p;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (tx_ready_o) begin
        tx_exp.push_back(exp);
        done = 1'b1;
      end
      tick();
    end
    tx_valid_i = 1'b0;
    if (!done) check("tx_handshake_timeout", 32'(done), 32'd1);
  endtask

  task automatic credit_pulse();
    rtr_credit_i = 1'b1;
    tick();
    rtr_credit_i = 1'b0;
  endtask

  task automatic rx_write(input logic [15:0] d, input bit stored);
    rtr_enable_i = 1'b1;
    rtr_data_i   = d;
    if (stored) rx_exp.push_back(d);
    tick();
    rtr_enable_i = 1'b0;
  endtask

  // Monitor: compares every sent flit, every popped RX flit and every credit-return pulse.
  initial begin
    logic [15:0] e;
    bit cred_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_exp.delete();
        rx_exp.delete();
        cred_pend = 1'b0;
      end else begin
        if (rtr_enable_o) begin
          if (tx_exp.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL tx_unexpected_send: got flit %0h, expected no send", rtr_data_o);
          end else begin
            e = tx_exp.pop_front();
            check("tx_flit", 32'(rtr_data_o), 32'(e));
          end
        end
        if (rtr_credit_o || cred_pend)
          check("rtr_credit_pulse", 32'(rtr_credit_o), 32'(cred_pend));
        cred_pend = rx_valid_o && rx_ready_i;
        if (rx_valid_o && rx_ready_i) begin
          if (rx_exp.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL rx_unexpected_pop: got flit %0h, expected empty queue", rx_data_o);
          end else begin
            e = rx_exp.pop_front();
            check("rx_flit", 32'(rx_data_o), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tx_valid_i = 1'b0; tx_dest_x_i = 4'h0; tx_dest_y_i = 4'h0; tx_payload_i = 8'h00;
    rtr_credit_i = 1'b0; rtr_data_i = 16'h0000; rtr_enable_i = 1'b0; rx_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check("rst_rtr_enable", 32'(rtr_enable_o), 32'd0);
    check("rst_rtr_data", 32'(rtr_data_o), 32'h0000);
    check("rst_rtr_credit", 32'(rtr_credit_o), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_tx_count", 32'(tx_count_o), 32'd0);
    check("rst_rx_count", 32'(rx_count_o), 32'd0);
    check("rst_credit_cnt", 32'(dut.credit_cnt_r), 32'd4);
    tick();

    // Single send with 2-cycle latency.
    send_pkt(4'h2, 4'h3, 8'hA5, 16'hA523);
    @(negedge clk);
    check("single_lat_cycle1_enable", 32'(rtr_enable_o), 32'd0);
    tick();
    @(negedge clk);
    check("single_lat_cycle2_enable", 32'(rtr_enable_o), 32'd1);
    check("single_credit_cnt", 32'(dut.credit_cnt_r), 32'd3);
    check("single_tx_count", 32'(tx_count_o), 32'd1);
    tick();
    credit_pulse();
    @(negedge clk);
    check("single_credit_back", 32'(dut.credit_cnt_r), 32'd4);
    tick();

    // Credit starvation: six flits, four credits.
    send_pkt(4'h1, 4'h2, 8'h11, 16'h1112);
    send_pkt(4'h3, 4'h4, 8'h22, 16'h2234);
    send_pkt(4'h5, 4'h6, 8'h33, 16'h3356);
    send_pkt(4'h7, 4'h8, 8'h44, 16'h4478);
    send_pkt(4'h9, 4'hA, 8'h55, 16'h559A);
    send_pkt(4'hF, 4'h0, 8'h66, 16'h66F0);
    repeat (4) tick();
    @(negedge clk);
    check("starve_tx_count", 32'(tx_count_o), 32'd5);
    check("starve_credit_cnt", 32'(dut.credit_cnt_r), 32'd0);
    check("starve_tx_ready", 32'(tx_ready_o), 32'd1);
    check("starve_no_send", 32'(rtr_enable_o), 32'd0);
    tick();
    credit_pulse();
    repeat (4) tick();
    @(negedge clk);
    check("starve_one_more_send", 32'(tx_count_o), 32'd6);
    tick();
    credit_pulse();
    repeat (4) tick();
    repeat (4) credit_pulse();
    @(negedge clk);
    check("starve_drained_count", 32'(tx_count_o), 32'd7);
    check("starve_credits_restored", 32'(dut.credit_cnt_r), 32'd4);
    check("starve_no_err", 32'(err_o), 32'd0);
    tick();

    // Credit return coinciding with the send at credit_cnt == 1.
    begin
      logic [7:0]  pay [5] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      logic [15:0] flt [5] = '{16'h8101, 16'h8223, 16'h8345, 16'h8467, 16'h8589};
      for (int i = 0; i < 5; i++) begin
        tx_valid_i   = 1'b1;
        tx_dest_x_i  = 4'(2 * i);
        tx_dest_y_i  = 4'(2 * i + 1);
        tx_payload_i = pay[i];
        rtr_credit_i = (i == 4);
        @(negedge clk);
        check("simul_tx_ready", 32'(tx_ready_o), 32'd1);
        if (tx_ready_o) tx_exp.push_back(flt[i]);
        tick();
      end
      tx_valid_i   = 1'b0;
      rtr_credit_i = 1'b0;
    end
    @(negedge clk);
    check("simul_credit_held", 32'(dut.credit_cnt_r), 32'd1);
    check("simul_enable_c5", 32'(rtr_enable_o), 32'd1);
    tick();
    @(negedge clk);
    check("simul_next_send", 32'(rtr_enable_o), 32'd1);
    check("simul_credit_after", 32'(dut.credit_cnt_r), 32'd0);
    check("simul_tx_count", 32'(tx_count_o), 32'd12);
    tick();
    repeat (4) credit_pulse();

    // Excess credit at full count.
    credit_pulse();
    @(negedge clk);
    check("excess_err", 32'(err_o), 32'd1);
    check("excess_credit_sat", 32'(dut.credit_cnt_r), 32'd4);
    tick();

    // RX overflow, then a write+pop on a full queue, then drain.
    rx_write(16'hBEEF, 1'b1);
    rx_write(16'h1234, 1'b1);
    rx_write(16'h5678, 1'b1);
    rx_write(16'h9ABC, 1'b1);
    rx_write(16'hDEAD, 1'b0);
    @(negedge clk);
    check("rx_ovf_err", 32'(err_o), 32'd3);
    check("rx_ovf_count", 32'(rx_count_o), 32'd4);
    check("rx_ovf_valid", 32'(rx_valid_o), 32'd1);
    check("rx_ovf_head", 32'(rx_data_o), 32'hBEEF);
    tick();
    rx_ready_i = 1'b1;
    rx_write(16'hF00D, 1'b1);
    repeat (4) tick();
    rx_ready_i = 1'b0;
    @(negedge clk);
    check("rx_drained_valid", 32'(rx_valid_o), 32'd0);
    check("rx_full_wr_pop_count", 32'(rx_count_o), 32'd5);
    check("tx_sb_drained", 32'(tx_exp.size()), 32'd0);
    check("rx_sb_drained", 32'(rx_exp.size()), 32'd0);
    tick();

    // Reset in the middle of a stream.
    rx_write(16'h7777, 1'b1);
    send_pkt(4'hA, 4'hB, 8'hC1, 16'hC1AB);
    send_pkt(4'hC, 4'hD, 8'hC2, 16'hC2CD);
    send_pkt(4'hE, 4'hF, 8'hC3, 16'hC3EF);
    check("midrst_pre_enable", 32'(rtr_enable_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_enable_drop", 32'(rtr_enable_o), 32'd0);
    check("midrst_credit_cnt", 32'(dut.credit_cnt_r), 32'd4);
    check("midrst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_tx_count", 32'(tx_count_o), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check("post_rst_credit_o", 32'(rtr_credit_o), 32'd0);
    repeat (6) tick();
    @(negedge clk);
    check("post_rst_tx_count", 32'(tx_count_o), 32'd0);
    check("post_rst_rx_count", 32'(rx_count_o), 32'd0);
    check("post_rst_enable", 32'(rtr_enable_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/noc_net_iface.md
NOC_NET_IFACE -- requirements
Module: noc_net_iface

Interface
REQ-001 Parameter XCOORD, default 0: this node's X coordinate, 4 bits used.
REQ-002 Parameter YCOORD, default 0: this node's Y coordinate, 4 bits used.
REQ-003 Parameter CREDITS, default 4: depth of the router local input buffer; the initial TX credit count.
REQ-004 Parameter TXQ_DEPTH, default 4: TX queue entries, power of two, at least 2.
REQ-005 Parameter RXQ_DEPTH, default 4: RX queue entries, power of two; equals the router local output port credit count.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 tx_valid_i  in  1  client offers a packet.
REQ-009 tx_ready_o  out  1  TX queue can accept a packet.
REQ-010 tx_dest_x_i  in  4  destination X.
REQ-011 tx_dest_y_i  in  4  destination Y.
REQ-012 tx_payload_i  in  8  payload byte.
REQ-013 rtr_data_o  out  16  flit to the router local input.
REQ-014 rtr_enable_o  out  1  flit write strobe to the router.
REQ-015 rtr_credit_i  in  1  one-cycle pulse: the router freed one local input slot.
REQ-016 rtr_data_i  in  16  flit from the router local output.
REQ-017 rtr_enable_i  in  1  flit valid from the router.
REQ-018 rtr_credit_o  out  1  one-cycle pulse: one RX slot freed.
REQ-019 rx_valid_o  out  1  RX queue head is valid.
REQ-020 rx_ready_i  in  1  client pops the RX head.
REQ-021 rx_data_o  out  16  RX head flit.
REQ-022 err_o  out  2  sticky errors: [0] credit overflow, [1] RX overflow.
REQ-023 tx_count_o  out  16  flits sent; wraps modulo 2^16.
REQ-024 rx_count_o  out  16  flits received; wraps modulo 2^16.

Function
REQ-025 Flit format: [15:8] payload, [7:4] destination X, [3:0] destination Y.
REQ-026 Single-flit packets only.
REQ-027 tx_ready_o = !txq_full, combinational from registered state.
REQ-028 A handshake (tx_valid_i && tx_ready_o) enqueues the packet that cycle.
REQ-029 TX FSM states:
- IDLE: queue empty.
- SEND: queue non-empty and credit_cnt > 0.
- WAIT_CRED: queue non-empty and credit_cnt == 0.
REQ-030 The FSM next state is evaluated each cycle from the post-update queue occupancy and credit_cnt.
REQ-031 In SEND: register the queue head onto rtr_data_o, pulse rtr_enable_o high the next cycle, dequeue, decrement credit_cnt, increment tx_count_o.
REQ-032 Sustained throughput is one flit per cycle while credits remain.
REQ-033 Minimum latency from enqueue into an empty queue to rtr_enable_o is 2 cycles.
REQ-034 rtr_data_o holds its last value when rtr_enable_o is low.
REQ-035 credit_cnt is a width clog2(CREDITS+1) counter, reset to CREDITS:
- +1 on rtr_credit_i.
- -1 on send.
- Both in the same cycle: unchanged.
REQ-036 An rtr_credit_i with credit_cnt == CREDITS and no send that cycle leaves credit_cnt saturated at CREDITS and sets err_o[0].
REQ-037 A simultaneous enqueue and dequeue on a full TX queue is legal (tx_ready_o is low, so no enqueue occurs); on a non-full queue, occupancy is unchanged.
REQ-038 rtr_enable_i writes rtr_data_i into the RX queue and increments rx_count_o.
REQ-039 rtr_enable_i while the RX queue is full and no pop occurs that cycle drops the flit, sets err_o[1], and leaves rx_count_o unchanged.
REQ-040 An RX write and an RX pop in the same cycle on a full RX queue are both accepted.
REQ-041 rx_valid_o = !rxq_empty; rx_data_o = queue head (first-word fall-through).
REQ-042 A pop (rx_valid_o && rx_ready_i) registers a rtr_credit_o pulse of exactly one cycle, the following cycle.
REQ-043 rtr_credit_o produces one pulse per pop, with no coalescing.
REQ-044 err_o bits are cleared only by reset.

Reset
REQ-045 On rst high, asynchronously: queues empty; FSM IDLE; credit_cnt = CREDITS; rtr_enable_o = 0; rtr_credit_o = 0; rtr_data_o = 0; err_o = 0; both counters = 0.
REQ-046 Reset asserted mid-transfer discards all queued flits and returns no credits.
REQ-047 tx_ready_o is 1 in the first cycle after reset release.

Verification
REQ-048 Single send: enqueue dest (2,3), payload 0xA5 -> rtr_data_o = 0xA523 with rtr_enable_o high 2 cycles later; credit_cnt 4->3; tx_count_o = 1.
REQ-049 Credit starvation: enqueue 6 flits with no rtr_credit_i -> 4 back-to-back sends, FSM in WAIT_CRED, tx_ready_o high; one rtr_credit_i -> exactly one more send.
REQ-050 Simultaneous credit and send with credit_cnt = 1 -> credit_cnt stays 1 and the next flit sends the following cycle.
REQ-051 Excess credit: rtr_credit_i at credit_cnt = 4 -> err_o = 2'b01; credit_cnt = 4.
REQ-052 RX: write 5 flits with rx_ready_i low -> 4 stored, err_o[1] = 1, rx_count_o = 4; pop 4 -> 4 rtr_credit_o pulses, each one cycle after its pop.
REQ-053 Reset mid-stream: assert rst with 3 flits queued -> rtr_enable_o drops immediately, credit_cnt = 4, rx_valid_o = 0.
